// File: rtl/fp_seq_pkg.sv
// Shared definitions for the field-arithmetic micro-sequencer: opcodes, FSM states and
// instruction field layout {op, dst, srcA, srcB}.
package fp_seq_pkg;

    localparam int unsigned SEQ_ADDR_W = 6;
    localparam int unsigned SEQ_PC_W   = 8;
    localparam int unsigned INSTR_W    = 3 + 3 * SEQ_ADDR_W;

    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_DIN  = 3'd1;
    localparam logic [2:0] OP_COPY = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_NOP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWrite,
        StFin
    } seq_state_e;

    // Field LSB positions for a given operand address width; srcB always sits at bit 0.
    localparam int unsigned SRCB_LSB = 0;

    function automatic int unsigned op_lsb(input int unsigned aw);
        return 3 * aw;
    endfunction

    function automatic int unsigned dst_lsb(input int unsigned aw);
        return 2 * aw;
    endfunction

    function automatic int unsigned srca_lsb(input int unsigned aw);
        return aw;
    endfunction

endpackage

// File: rtl/fp_seq_lat_cnt.sv
// Down-counter timing the fixed add/sub latency; zero is high on the last EXEC cycle.
module fp_seq_lat_cnt #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fp_ins_sequencer.sv
// Micro-sequencer: fetches instructions from the program ROM and drives operand RAM
// addressing, result-mux select, multiplier launch and write-back.
module fp_ins_sequencer
    import fp_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = SEQ_ADDR_W,
    parameter int unsigned PC_W    = SEQ_PC_W,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PC_W-1:0]       prog_len,
    output logic                  busy,
    output logic                  done,
    output logic [PC_W-1:0]       rom_addr,
    input  logic [3+3*ADDR_W-1:0] rom_data,
    output logic [ADDR_W-1:0]     ram_addra,
    output logic [ADDR_W-1:0]     ram_addrb,
    output logic                  ram_we,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  d_in,
    output logic [2:0]            INS,
    output logic                  mul_start,
    input  logic                  mul_done
);

    localparam int unsigned IW       = 3 + 3 * ADDR_W;
    localparam int unsigned OP_LSB   = op_lsb(ADDR_W);
    localparam int unsigned DST_LSB  = dst_lsb(ADDR_W);
    localparam int unsigned SRCA_LSB = srca_lsb(ADDR_W);

    seq_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   len_q, len_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic              first_q, first_d;
    logic              lat_load;
    logic              lat_zero;

    logic [2:0]        ir_op;
    logic [ADDR_W-1:0] ir_dst, ir_srca, ir_srcb;
    logic [2:0]        rom_op;
    logic [PC_W-1:0]   pc_inc;

    assign ir_op   = ir_q[OP_LSB +: 3];
    assign ir_dst  = ir_q[DST_LSB +: ADDR_W];
    assign ir_srca = ir_q[SRCA_LSB +: ADDR_W];
    assign ir_srcb = ir_q[SRCB_LSB +: ADDR_W];
    assign rom_op  = rom_data[OP_LSB +: 3];
    assign pc_inc  = pc_q + PC_W'(1);

    fp_seq_lat_cnt #(
        .LAT (ADD_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (lat_load),
        .zero (lat_zero)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        ir_d      = ir_q;
        first_d   = 1'b0;
        lat_load  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rom_addr  = '0;
        ram_addra = '0;
        ram_addrb = '0;
        ram_we    = 1'b0;
        din_ready = 1'b0;
        d_in      = 1'b0;
        INS       = 3'd0;
        mul_start = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    state_d = (prog_len == '0) ? StFin : StFetch;
                end
            end
            StFetch: begin
                busy     = 1'b1;
                rom_addr = pc_q;
                state_d  = StDecode;
            end
            StDecode: begin
                busy      = 1'b1;
                ir_d      = rom_data;
                ram_addra = rom_data[SRCA_LSB +: ADDR_W];
                ram_addrb = rom_data[SRCB_LSB +: ADDR_W];
                if (rom_op == OP_HALT) begin
                    state_d = StFin;
                end else begin
                    state_d  = StExec;
                    first_d  = 1'b1;
                    lat_load = 1'b1;
                end
            end
            StExec: begin
                busy      = 1'b1;
                INS       = ir_op;
                ram_addra = ir_srca;
                ram_addrb = ir_srcb;
                case (ir_op)
                    OP_ZERO, OP_COPY: state_d = StWrite;
                    OP_DIN: begin
                        din_ready = 1'b1;
                        d_in      = 1'b1;
                        if (din_valid) state_d = StWrite;
                    end
                    OP_ADD, OP_SUB: begin
                        if (lat_zero) state_d = StWrite;
                    end
                    OP_MUL: begin
                        // A mul_done coincident with the launch cannot belong to this op.
                        mul_start = first_q;
                        if (!first_q && mul_done) state_d = StWrite;
                    end
                    OP_NOP: begin
                        pc_d    = pc_inc;
                        state_d = (pc_inc == len_q) ? StFin : StFetch;
                    end
                    default: state_d = StFin;
                endcase
            end
            StWrite: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addra = ir_dst;
                INS       = ir_op;
                d_in      = (ir_op == OP_DIN);
                pc_d      = pc_inc;
                state_d   = (pc_inc == len_q) ? StFin : StFetch;
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset aborts in the same cycle: no strobe may escape while rst is high.
        if (rst) begin
            ram_we    = 1'b0;
            mul_start = 1'b0;
            din_ready = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            ir_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_fp_ins_sequencer.sv
// Scoreboard bench for fp_ins_sequencer: directed programs push expected strobe events,
// a negedge monitor pops and compares every mul_start, ram_we and done it observes.
module tb_fp_ins_sequencer;

    localparam int AW = 6;
    localparam int PW = 8;
    localparam int IW = 3 + 3 * AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] prog_len = '0;
    logic          busy, done;
    logic [PW-1:0] rom_addr;
    logic [IW-1:0] rom_data = '0;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic          ram_we;
    logic          din_valid = 1'b0;
    logic          din_ready, d_in;
    logic [2:0]    INS;
    logic          mul_start;
    logic          mul_done = 1'b0;

    logic [IW-1:0] rom [0:255];
    logic [28:0]   all_outs;

    typedef struct {
        int kind;  // 0 write, 1 done, 2 mul_start
        int cyc;
        int addr;
        int ins;
        int din;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  s;

    fp_ins_sequencer #(
        .ADDR_W  (AW),
        .PC_W    (PW),
        .ADD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_len  (prog_len),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addra (ram_addra),
        .ram_addrb (ram_addrb),
        .ram_we    (ram_we),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .d_in      (d_in),
        .INS       (INS),
        .mul_start (mul_start),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    assign all_outs = {busy, done, rom_addr, ram_addra, ram_addrb, ram_we, din_ready, d_in,
                       INS, mul_start};

    function automatic logic [IW-1:0] enc(input int op, input int dst, input int a,
                                          input int b);
        return {op[2:0], dst[AW-1:0], a[AW-1:0], b[AW-1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int addr, input int ins,
                        input int din);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = addr;
        e.ins  = ins;
        e.din  = din;
        exp_q.push_back(e);
    endtask

    task automatic score(input int kind, input int addr, input int ins, input int din);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind=%0d cyc=%0d addr=%0d ins=%0d din=%0d, required none",
                     kind, cyc, addr, ins, din);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.addr != addr || e.ins != ins ||
                e.din != din) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d addr=%0d ins=%0d din=%0d, required kind=%0d cyc=%0d addr=%0d ins=%0d din=%0d",
                         kind, cyc, addr, ins, din, e.kind, e.cyc, e.addr, e.ins, e.din);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mul_start === 1'b1) score(2, 0, int'(INS), int'(d_in));
            if (ram_we === 1'b1) score(0, int'(ram_addra), int'(INS), int'(d_in));
            if (done === 1'b1) score(1, 0, int'(INS), int'(d_in));
        end
    end

    // Advance to just after the posedge that makes cyc == c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick(input int len, output int s0);
        s0 = cyc;
        start = 1'b1;
        prog_len = len[PW-1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: got no done, required done within %0d cycles", limit);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;

        // Reset, then idle with everything quiet.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("outs_in_reset", 64'(all_outs), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("outs_idle", 64'(all_outs), 64'd0);
        @(posedge clk);
        #1;

        // add dst=5 srcA=1 srcB=2; start seen at cycle s, FETCH at s+1, WRITE at s+4.
        rom[0] = enc(3, 5, 1, 2);
        kick(1, s);
        push(0, s + 4, 5, 3, 0);
        push(1, s + 5, 0, 0, 0);
        @(negedge clk);
        chk("add_fetch", 64'({busy, rom_addr}), 64'({1'b1, 8'd0}));
        goto(s + 2);
        @(negedge clk);
        chk("add_decode_addr", 64'({ram_addra, ram_addrb}), 64'({6'd1, 6'd2}));
        goto(s + 3);
        @(negedge clk);
        chk("add_exec_ins", 64'(INS), 64'd3);
        wait_done(20);

        // Stray mul_done in IDLE, then mul with mul_done 7 cycles after mul_start.
        mul_done = 1'b1;
        @(posedge clk);
        #1;
        mul_done = 1'b0;
        @(negedge clk);
        chk("stray_mul_done_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rom[0] = enc(5, 7, 3, 4);
        kick(1, s);
        push(2, s + 3, 0, 5, 0);
        push(0, s + 11, 7, 5, 0);
        push(1, s + 12, 0, 0, 0);
        goto(s + 6);
        @(negedge clk);
        chk("mul_wait_ins", 64'({busy, INS, ram_we}), 64'({1'b1, 3'd5, 1'b0}));
        goto(s + 10);
        mul_done = 1'b1;
        goto(s + 11);
        mul_done = 1'b0;
        wait_done(20);

        // din with din_valid low for 3 EXEC cycles; handshake at s+6, WRITE at s+7.
        rom[0] = enc(1, 10, 0, 0);
        kick(1, s);
        push(0, s + 7, 10, 1, 1);
        push(1, s + 8, 0, 0, 0);
        for (int k = 3; k <= 6; k++) begin
            goto(s + k);
            if (k == 6) din_valid = 1'b1;
            @(negedge clk);
            chk("din_exec_hold", 64'({din_ready, d_in, INS}), 64'({1'b1, 1'b1, 3'd1}));
        end
        goto(s + 7);
        din_valid = 1'b0;
        @(negedge clk);
        chk("din_write_ready_low", 64'(din_ready), 64'd0);
        wait_done(20);

        // {NOP, copy 4->9, HALT, add}: NOP refetches at s+4, copy writes at s+7, HALT ends.
        rom[0] = enc(6, 0, 0, 0);
        rom[1] = enc(2, 9, 4, 0);
        rom[2] = enc(7, 0, 0, 0);
        rom[3] = enc(3, 11, 1, 1);
        kick(4, s);
        push(0, s + 7, 9, 2, 0);
        push(1, s + 10, 0, 0, 0);
        goto(s + 4);
        @(negedge clk);
        chk("prog_fetch_pc1", 64'(rom_addr), 64'd1);
        goto(s + 8);
        @(negedge clk);
        chk("prog_fetch_pc2", 64'(rom_addr), 64'd2);
        wait_done(30);
        goto(cyc + 6);
        @(negedge clk);
        chk("prog_idle_after_halt", 64'(busy), 64'd0);

        // prog_len=0 goes straight to FIN.
        kick(0, s);
        push(1, s + 1, 0, 0, 0);
        @(negedge clk);
        chk("len0_fin", 64'({busy, rom_addr}), 64'd0);
        goto(s + 3);

        // start during busy is ignored (prog_len=5 must not be latched).
        rom[0] = enc(2, 3, 6, 0);
        kick(1, s);
        push(0, s + 4, 3, 2, 0);
        push(1, s + 5, 0, 0, 0);
        goto(s + 2);
        start = 1'b1;
        prog_len = 8'd5;
        goto(s + 3);
        start = 1'b0;
        prog_len = 8'd0;
        goto(s + 12);
        @(negedge clk);
        chk("busy_start_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Reset during the mul wait: nothing escapes, IDLE the next cycle.
        rom[0] = enc(5, 8, 1, 1);
        kick(1, s);
        push(2, s + 3, 0, 5, 0);
        goto(s + 6);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_strobes", 64'({ram_we, mul_start, done}), 64'd0);
        goto(s + 7);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle_outs", 64'(all_outs), 64'd0);
        goto(s + 8);
        mul_done = 1'b1;
        goto(s + 9);
        mul_done = 1'b0;
        goto(s + 14);
        @(negedge clk);
        chk("rst_stays_idle", 64'(busy), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
